// File: rtl/free_reg_pool_if.sv
// free_reg_pool_if: rename/commit side bundle of the physical tag free pool.
// Latency: none; wires only. Grant/addr/stall are driven combinationally by the pool.
// Backpressure: the pool answers a request with alloc_grant or stall; free strobes are always accepted.
interface free_reg_pool_if #(
  parameter int NUM_REG     = 64,
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2,
  parameter int NUM_CP      = 4
);
  localparam int TW = $clog2(NUM_REG);
  localparam int CW = $clog2(NUM_CP);

  logic [ALLOC_PORTS-1:0]          alloc_req;
  logic                            alloc_grant;
  logic [ALLOC_PORTS-1:0][TW-1:0]  alloc_addr;
  logic                            stall;
  logic [FREE_PORTS-1:0]           free_valid;
  logic [FREE_PORTS-1:0][TW-1:0]   free_addr;
  logic                            cp_save;
  logic [CW-1:0]                   cp_save_id;
  logic                            cp_restore;
  logic [CW-1:0]                   cp_restore_id;
  logic                            cp_release;
  logic [CW-1:0]                   cp_release_id;
  logic [TW:0]                     free_count;
  logic                            dbl_free;

  modport master (
    output alloc_req, free_valid, free_addr,
    output cp_save, cp_save_id, cp_restore, cp_restore_id, cp_release, cp_release_id,
    input  alloc_grant, alloc_addr, stall, free_count, dbl_free
  );

  modport slave (
    input  alloc_req, free_valid, free_addr,
    input  cp_save, cp_save_id, cp_restore, cp_restore_id, cp_release, cp_release_id,
    output alloc_grant, alloc_addr, stall, free_count, dbl_free
  );
endinterface

// File: rtl/free_reg_pool.sv
// free_reg_pool: multi-port physical tag free pool; branch checkpoints built only with FRL_CHECKPOINT_EN.
// Latency: grant/addr/stall combinational; pool, free_count and dbl_free update on the next posedge.
// Backpressure: all-or-nothing grant; stall when requested tags exceed free tags, nothing is taken.
module free_reg_pool #(
  parameter int NUM_REG     = 64,
  parameter int ALLOC_PORTS = 2,
  parameter int FREE_PORTS  = 2,
  parameter int NUM_CP      = 4
) (
  input  logic           clk,
  input  logic           rst,
  free_reg_pool_if.slave bus
);
  localparam int TW = $clog2(NUM_REG);

  logic [NUM_REG-1:0]             free_q, free_d;
  logic [TW:0]                    count_q, count_d;
  logic                           dbl_q, dbl_d;

  logic [NUM_REG-1:0]             avail_c;
  logic [NUM_REG-1:0]             take_c;
  logic [NUM_REG-1:0]             ret_c;
  logic [ALLOC_PORTS-1:0][TW-1:0] addr_c;
  logic                           all_found_c;
  logic                           found_c;
  logic                           grant_c;
  logic                           restore_hit_c;
  logic [NUM_REG-1:0]             restore_vec_c;

  function automatic logic [TW:0] popcnt(input logic [NUM_REG-1:0] v);
    logic [TW:0] c;
    c = '0;
    for (int i = 0; i < NUM_REG; i++) c = c + {{TW{1'b0}}, v[i]};
    return c;
  endfunction

  // Walk requesting ports oldest first, each taking the lowest free tag not already handed out.
  always_comb begin
    avail_c     = free_q;
    addr_c      = '0;
    all_found_c = 1'b1;
    found_c     = 1'b0;
    for (int p = 0; p < ALLOC_PORTS; p++) begin
      found_c = 1'b0;
      if (bus.alloc_req[p]) begin
        for (int r = 0; r < NUM_REG; r++) begin
          if (!found_c && avail_c[r]) begin
            addr_c[p]  = TW'(r);
            avail_c[r] = 1'b0;
            found_c    = 1'b1;
          end
        end
        if (!found_c) all_found_c = 1'b0;
      end
    end
  end

  // A successful restore owns the cycle: no grant and no stall, the rename side replays later.
  assign grant_c         = all_found_c && !restore_hit_c;
  assign take_c          = grant_c ? (free_q & ~avail_c) : '0;
  assign bus.alloc_grant = grant_c;
  assign bus.stall       = !all_found_c && !restore_hit_c;
  assign bus.alloc_addr  = addr_c;
  assign bus.free_count  = count_q;
  assign bus.dbl_free    = dbl_q;

  // Decode returned tags into a mask; flag any tag that was already sitting in the pool.
  always_comb begin
    ret_c = '0;
    dbl_d = 1'b0;
    for (int f = 0; f < FREE_PORTS; f++) begin
      if (bus.free_valid[f]) begin
        ret_c[bus.free_addr[f]] = 1'b1;
        if (free_q[bus.free_addr[f]]) dbl_d = 1'b1;
      end
    end
  end

  // Next pool: grants cleared, returns set; a restore replaces the pool but still keeps this cycle's returns.
  always_comb begin
    free_d = (free_q & ~take_c) | ret_c;
    if (restore_hit_c) free_d = restore_vec_c | ret_c;
    count_d = popcnt(free_d);
  end

  // Pool state, registered count and double-free pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q  <= '1;
      count_q <= (TW+1)'(NUM_REG);
      dbl_q   <= 1'b0;
    end else begin
      free_q  <= free_d;
      count_q <= count_d;
      dbl_q   <= dbl_d;
    end
  end

`ifdef FRL_CHECKPOINT_EN
  logic [NUM_REG-1:0] cp_q [NUM_CP];
  logic [NUM_REG-1:0] cp_d [NUM_CP];
  logic [NUM_CP-1:0]  cp_vld_q, cp_vld_d;

  assign restore_hit_c = bus.cp_restore && cp_vld_q[bus.cp_restore_id];
  assign restore_vec_c = cp_q[bus.cp_restore_id];

  // Live snapshots absorb every return so a later restore cannot leak a committed tag.
  // Restore beats save; save beats release on the same slot.
  always_comb begin
    cp_vld_d = cp_vld_q;
    for (int i = 0; i < NUM_CP; i++) begin
      cp_d[i] = cp_vld_q[i] ? (cp_q[i] | ret_c) : cp_q[i];
    end
    if (bus.cp_release) cp_vld_d[bus.cp_release_id] = 1'b0;
    if (restore_hit_c)  cp_vld_d[bus.cp_restore_id] = 1'b0;
    if (bus.cp_save && !bus.cp_restore) begin
      cp_d[bus.cp_save_id]     = free_d;
      cp_vld_d[bus.cp_save_id] = 1'b1;
    end
  end

  // Snapshot storage and slot valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CP; i++) cp_q[i] <= '1;
      cp_vld_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CP; i++) cp_q[i] <= cp_d[i];
      cp_vld_q <= cp_vld_d;
    end
  end
`else
  logic unused_cp;

  assign restore_hit_c = 1'b0;
  assign restore_vec_c = '1;
  assign unused_cp     = ^{bus.cp_save, bus.cp_save_id, bus.cp_restore, bus.cp_restore_id,
                           bus.cp_release, bus.cp_release_id};
`endif

endmodule

// File: tb/tb_free_reg_pool.sv
// tb_free_reg_pool: directed vectors on an 8-tag pool, scoreboard queue checked by a negedge monitor.
// Latency: comb outputs checked in the issuing cycle, free_count/dbl_free one cycle later.
// Backpressure: stall cycles are driven deliberately and checked like any other response.
module tb_free_reg_pool;
  localparam int NR = 8;
  localparam int AP = 2;
  localparam int FP = 2;
  localparam int NC = 4;
  localparam int TW = 3;
  localparam int CW = 2;

  typedef struct {
    int    cyc;
    int    kind;
    string name;
    int    val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q[$];
  exp_t mon_e;
  int   mon_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  free_reg_pool_if #(.NUM_REG(NR), .ALLOC_PORTS(AP), .FREE_PORTS(FP), .NUM_CP(NC)) bus ();

  free_reg_pool #(.NUM_REG(NR), .ALLOC_PORTS(AP), .FREE_PORTS(FP), .NUM_CP(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic int actual(input int kind);
    case (kind)
      0:       return int'(bus.alloc_grant);
      1:       return int'(bus.stall);
      2:       return int'(bus.alloc_addr[0]);
      3:       return int'(bus.alloc_addr[1]);
      4:       return int'(bus.free_count);
      default: return int'(bus.dbl_free);
    endcase
  endfunction

  // Monitor: pop every expectation due this cycle; anything overdue is a failure.
  always @(negedge clk) begin
    for (int i = 0; i < q.size(); ) begin
      if (q[i].cyc <= cyc) begin
        mon_e = q[i];
        mon_a = actual(mon_e.kind);
        n_chk++;
        if (mon_e.cyc == cyc && mon_a == mon_e.val) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (due cycle %0d, now %0d)",
                      mon_e.name, mon_a, mon_e.val, mon_e.cyc, cyc);
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push(input int c, input int kind, input string name, input int val);
    exp_t e;
    e.cyc = c; e.kind = kind; e.name = name; e.val = val;
    q.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_req     = '0;
    bus.free_valid    = '0;
    bus.free_addr     = '0;
    bus.cp_save       = 1'b0;
    bus.cp_save_id    = '0;
    bus.cp_restore    = 1'b0;
    bus.cp_restore_id = '0;
    bus.cp_release    = 1'b0;
    bus.cp_release_id = '0;
  endtask

  // One cycle of stimulus; -1 in an expected field means "not checked".
  task automatic step(input logic [1:0] req, input logic [1:0] fv, input int fa0, input int fa1,
                      input logic sv, input int sid, input logic rs, input int rid,
                      input logic rl, input int rlid,
                      input int g, input int s, input int a0, input int a1,
                      input int cnt, input int dbl, input string nm);
    bus.alloc_req     = req;
    bus.free_valid    = fv;
    bus.free_addr[0]  = fa0[TW-1:0];
    bus.free_addr[1]  = fa1[TW-1:0];
    bus.cp_save       = sv;
    bus.cp_save_id    = sid[CW-1:0];
    bus.cp_restore    = rs;
    bus.cp_restore_id = rid[CW-1:0];
    bus.cp_release    = rl;
    bus.cp_release_id = rlid[CW-1:0];
    push(cyc, 0, {nm, ".grant"}, g);
    push(cyc, 1, {nm, ".stall"}, s);
    if (a0 >= 0)  push(cyc, 2, {nm, ".addr0"}, a0);
    if (a1 >= 0)  push(cyc, 3, {nm, ".addr1"}, a1);
    if (cnt >= 0) push(cyc + 1, 4, {nm, ".free_count"}, cnt);
    if (dbl >= 0) push(cyc + 1, 5, {nm, ".dbl_free"}, dbl);
    next();
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while (q.size() > 0 && n < 8) begin
      next();
      n++;
    end
    if (q.size() > 0) begin
      $display("FAIL drain: %0d checks never reached, expected 0", q.size());
      n_chk += q.size();
      q.delete();
    end
  endtask

  task automatic check_reset_state(input string nm);
    push(cyc, 4, {nm, ".free_count"}, NR);
    push(cyc, 5, {nm, ".dbl_free"}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");
    //   req   fv    fa0 fa1 sv sid rs rid rl rlid  g  s  a0  a1 cnt dbl name
    step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0,  0,  1, 6, 0, "alloc01");
    step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0,  2,  3, 4, 0, "alloc23");
    step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0,  4,  5, 2, 0, "alloc45");
    step(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0,  6, -1, 1, 0, "alloc6");
    step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,     0, 1, -1, -1, 1, 0, "stall_full");
    step(2'b11, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0,     0, 1, -1, -1, 2, 0, "stall_free3");
    step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0,  3,  7, 0, 0, "grant37");
    step(2'b00, 2'b01, 6, 0, 0, 0, 0, 0, 0, 0,     1, 0, -1, -1, 1, 0, "free6");
    step(2'b00, 2'b01, 6, 0, 0, 0, 0, 0, 0, 0,     1, 0, -1, -1, 1, 1, "dblfree6");
    step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0, -1, -1, 1, 0, "dbl_pulse_end");
    step(2'b00, 2'b11, 4, 4, 0, 0, 0, 0, 0, 0,     1, 0, -1, -1, 2, 0, "free4_twice");
    step(2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0,     1, 0,  4, -1, 1, 0, "restore_unsaved");
    step(2'b11, 2'b11, 4, 6, 0, 0, 0, 0, 0, 0,     0, 1, -1, -1, 2, 1, "stall_dbl6");
`ifdef FRL_CHECKPOINT_EN
    drain();
    rst = 1'b1;
    next();
    rst = 1'b0;
    check_reset_state("reset2");
    step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0,  0,  1, 6, 0, "cp_alloc01");
    step(2'b11, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0,     1, 0,  2,  3, 4, 0, "cp_save1");
    step(2'b11, 2'b01, 2, 0, 0, 0, 0, 0, 0, 0,     1, 0,  4,  5, 3, 0, "cp_alloc45_free2");
    step(2'b11, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0,     0, 0, -1, -1, 5, 0, "cp_restore1");
    step(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0,  2,  4, 3, 0, "cp_after_restore");
    step(2'b01, 2'b00, 0, 0, 1, 2, 0, 0, 0, 0,     1, 0,  5, -1, 2, 0, "cp_save2");
    step(2'b01, 2'b01, 5, 0, 0, 0, 1, 2, 0, 0,     0, 0, -1, -1, 3, 0, "cp_restore2_free5");
    step(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0,  5, -1, 2, 0, "cp_tag5_back");
    step(2'b01, 2'b00, 0, 0, 0, 0, 1, 2, 0, 0,     1, 0,  6, -1, 1, 0, "cp_restore_used");
    step(2'b00, 2'b00, 0, 0, 1, 3, 0, 0, 0, 0,     1, 0, -1, -1, 1, 0, "cp_save3");
    step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 3,     1, 0, -1, -1, 1, 0, "cp_release3");
    step(2'b01, 2'b00, 0, 0, 0, 0, 1, 3, 0, 0,     1, 0,  7, -1, 0, 0, "cp_restore_released");
    step(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 1, 0,     1, 0, -1, -1, 0, 0, "cp_save_vs_release");
    step(2'b00, 2'b01, 7, 0, 0, 0, 0, 0, 0, 0,     1, 0, -1, -1, 1, 0, "cp_free7");
    step(2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0,     0, 0, -1, -1, 1, 0, "cp_restore0");
    step(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0,  7, -1, 0, 0, "cp_alloc7");
    step(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0,     1, 0, -1, -1, 0, 0, "cp_save1_again");
`else
    step(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0,     1, 0, -1, -1, 2, 0, "nocp_save0");
    step(2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0,     1, 0,  4, -1, 1, 0, "nocp_restore0");
`endif
    drain();
    // Reset lands in the middle of a restore cycle.
    bus.alloc_req     = 2'b11;
    bus.cp_restore    = 1'b1;
    bus.cp_restore_id = 2'd1;
    #2 rst = 1'b1;
    push(cyc, 0, "rst_mid.grant", 1);
    push(cyc, 1, "rst_mid.stall", 0);
    push(cyc, 2, "rst_mid.addr0", 0);
    push(cyc, 3, "rst_mid.addr1", 1);
    next();
    rst = 1'b0;
    check_reset_state("rst_mid");
    step(2'b11, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0,     1, 0,  0,  1, 6, 0, "post_rst_restore");
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
